// File: rtl/array_mac_seq_if.sv
// Start/busy/done bus of the sequential vector reduction engine.
//
// Handshake: start is sampled only while the engine is idle (busy=0) and
// launches one operation on the operands/mode present at that edge. busy
// stays high for the whole reduction. done pulses for exactly one cycle when
// sum takes the new result. start while busy is dropped, not queued. start
// during the done cycle is accepted, giving back-to-back operation.
interface array_mac_seq_if #(
  parameter int N = 10,
  parameter int W = 8
);
  localparam int OUT_W = 2 * W + $clog2(N);

  logic             start;
  logic [1:0]       mode;
  logic [N*W-1:0]   num1;
  logic [N*W-1:0]   num2;
  logic             busy;
  logic             done;
  logic [OUT_W-1:0] sum;
  logic             state_dbg;  // 0 = IDLE, 1 = RUN

  modport master (
    output start, mode, num1, num2,
    input  busy, done, sum, state_dbg
  );

  modport slave (
    input  start, mode, num1, num2,
    output busy, done, sum, state_dbg
  );
endinterface

// File: rtl/array_mac_seq.sv
// Sequential vector reduction: latches two N-element vectors on start and
// reduces LANES element pairs per clock as sum, dot product or SAD.
module array_mac_seq #(
  parameter int N     = 10,
  parameter int W     = 8,
  parameter int LANES = 1
) (
  input  logic          clk,
  input  logic          res,
  array_mac_seq_if.slave bus
);

  localparam int OUT_W = 2 * W + $clog2(N);
  // Index must hold idx+LANES, which can exceed N on the last pass.
  localparam int IDX_W = $clog2(N + LANES + 1);
  localparam logic [IDX_W-1:0] N_I     = IDX_W'(N);
  localparam logic [IDX_W-1:0] LANES_I = IDX_W'(LANES);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [N*W-1:0]   a_q, a_d;
  logic [N*W-1:0]   b_q, b_d;
  logic [1:0]       mode_q, mode_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] sum_q, sum_d;
  logic             done_q, done_d;
  logic [OUT_W-1:0] lane_sum;
  logic             last_pass;

  // Per-cycle contribution of the LANES element pairs starting at idx;
  // lanes past the end of the vector contribute nothing.
  always_comb begin
    logic [IDX_W-1:0] j;
    logic [W-1:0]     ea;
    logic [W-1:0]     eb;
    logic [OUT_W-1:0] f;
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      j  = idx_q + IDX_W'(l);
      ea = '0;
      eb = '0;
      f  = '0;
      if (j < N_I) begin
        ea = a_q[int'(j)*W +: W];
        eb = b_q[int'(j)*W +: W];
        case (mode_q)
          2'b00:   f = OUT_W'(ea) + OUT_W'(eb);
          2'b01:   f = OUT_W'(ea) * OUT_W'(eb);
          2'b10:   f = (ea >= eb) ? OUT_W'(ea - eb) : OUT_W'(eb - ea);
          default: f = '0;
        endcase
      end
      lane_sum = lane_sum + f;
    end
  end

  assign last_pass = (idx_q + LANES_I) >= N_I;

  // Next-state and datapath control for the IDLE/RUN sequencer.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    mode_d  = mode_q;
    acc_d   = acc_q;
    idx_d   = idx_q;
    sum_d   = sum_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          a_d     = bus.num1;
          b_d     = bus.num2;
          mode_d  = bus.mode;
          acc_d   = '0;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d = acc_q + lane_sum;
        idx_d = idx_q + LANES_I;
        if (last_pass) begin
          sum_d   = acc_q + lane_sum;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any operation silently.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      mode_q  <= '0;
      acc_q   <= '0;
      idx_q   <= '0;
      sum_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
      acc_q   <= acc_d;
      idx_q   <= idx_d;
      sum_q   <= sum_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = done_q;
  assign bus.sum       = sum_q;
  assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_array_mac_seq.sv
// Directed bench for array_mac_seq: a LANES=1 and a LANES=3 instance share
// operand vectors but have separate start lines.
module tb_array_mac_seq;

  logic clk;
  logic res;
  int   vectors;
  int   miscompares;

  array_mac_seq_if #(.N(10), .W(8)) if1 ();
  array_mac_seq_if #(.N(10), .W(8)) if3 ();

  array_mac_seq #(.N(10), .W(8), .LANES(1)) dut1 (.clk(clk), .res(res), .bus(if1.slave));
  array_mac_seq #(.N(10), .W(8), .LANES(3)) dut3 (.clk(clk), .res(res), .bus(if3.slave));

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Element lists are written element 9 first, element 0 last.
  int va1 [10] = '{2, 4, 6, 8, 10, 12, 14, 16, 18, 20};
  int vb1 [10] = '{1, 3, 5, 7, 9, 11, 13, 15, 17, 19};
  int va2 [10] = '{5, 4, 3, 2, 1, 1, 2, 3, 4, 5};
  int vb2 [10] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10};
  int vmx [10] = '{255, 255, 255, 255, 255, 255, 255, 255, 255, 255};

  function automatic logic [79:0] pack10(input int v [10]);
    logic [79:0] r;
    r = '0;
    for (int i = 0; i < 10; i++) r[(9-i)*8 +: 8] = v[i][7:0];
    return r;
  endfunction

  // Driver tasks
  task automatic set_vec(input logic [79:0] a, input logic [79:0] b);
    if1.num1 = a; if1.num2 = b;
    if3.num1 = a; if3.num2 = b;
  endtask

  task automatic start_op(input bit l3, input logic [1:0] m);
    if (l3) begin if3.mode = m; if3.start = 1'b1; end
    else    begin if1.mode = m; if1.start = 1'b1; end
    @(posedge clk); #1;
    if3.start = 1'b0;
    if1.start = 1'b0;
  endtask

  // Counts cycles after the start edge until done; -1 if it never comes.
  task automatic wait_done(input bit l3, output int cyc, output int busy_cyc,
                           output logic [19:0] s);
    cyc = -1;
    busy_cyc = 0;
    s = '0;
    if (l3 ? if3.busy : if1.busy) busy_cyc++;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (l3 ? if3.done : if1.done) begin
        cyc = i;
        s = l3 ? if3.sum : if1.sum;
        break;
      end
      if (l3 ? if3.busy : if1.busy) busy_cyc++;
    end
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (if1.done) n++;
    end
  endtask

  // Tests
  task automatic test_reset();
    res = 1'b0;
    if1.start = 1'b0; if1.mode = 2'b00; if1.num1 = '0; if1.num2 = '0;
    if3.start = 1'b0; if3.mode = 2'b00; if3.num1 = '0; if3.num2 = '0;
    @(negedge clk);
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", if1.busy); end
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL reset_done got %b want 0", if1.done); end
    vectors++; if (if1.sum !== 20'd0) begin miscompares++; $display("FAIL reset_sum got %0d want 0", if1.sum); end
    vectors++; if (if1.state_dbg !== 1'b0) begin miscompares++; $display("FAIL reset_state got %b want 0", if1.state_dbg); end
    res = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mode_sum();
    int cyc, bcyc;
    logic [19:0] s;
    set_vec(pack10(va1), pack10(vb1));
    start_op(1'b0, 2'b00);
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (cyc !== 10) begin miscompares++; $display("FAIL sum_latency got %0d want 10", cyc); end
    vectors++; if (bcyc !== 10) begin miscompares++; $display("FAIL sum_busy_cycles got %0d want 10", bcyc); end
    vectors++; if (s !== 20'd210) begin miscompares++; $display("FAIL sum_result got %0d want 210", s); end
    @(posedge clk); #1;
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL sum_done_width got %b want 0", if1.done); end
    vectors++; if (if1.sum !== 20'd210) begin miscompares++; $display("FAIL sum_hold got %0d want 210", if1.sum); end
  endtask

  task automatic test_back_to_back();
    int cyc, bcyc;
    logic [19:0] s;
    set_vec(pack10(va1), pack10(vb1));
    start_op(1'b0, 2'b01);
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (cyc !== 10) begin miscompares++; $display("FAIL b2b_dot_latency got %0d want 10", cyc); end
    vectors++; if (s !== 20'd1430) begin miscompares++; $display("FAIL b2b_dot_result got %0d want 1430", s); end
    // still in the done cycle: start is accepted here
    start_op(1'b0, 2'b10);
    vectors++; if (if1.sum !== 20'd1430) begin miscompares++; $display("FAIL b2b_sum_not_cleared got %0d want 1430", if1.sum); end
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (cyc !== 10) begin miscompares++; $display("FAIL b2b_sad_latency got %0d want 10", cyc); end
    vectors++; if (s !== 20'd10) begin miscompares++; $display("FAIL b2b_sad_result got %0d want 10", s); end
  endtask

  task automatic test_mixed_vectors();
    int cyc, bcyc;
    logic [19:0] s;
    set_vec(pack10(va2), pack10(vb2));
    start_op(1'b0, 2'b00);
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (s !== 20'd85) begin miscompares++; $display("FAIL mix_sum got %0d want 85", s); end
    start_op(1'b0, 2'b01);
    // operands and mode change while running must not matter
    repeat (2) @(posedge clk);
    if1.num1 = '0; if1.mode = 2'b00;
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (s !== 20'd165) begin miscompares++; $display("FAIL mix_dot_operand_change got %0d want 165", s); end
    set_vec(pack10(va2), pack10(vb2));
    start_op(1'b0, 2'b10);
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (s !== 20'd37) begin miscompares++; $display("FAIL mix_sad got %0d want 37", s); end
  endtask

  task automatic test_max_and_reserved();
    int cyc, bcyc;
    logic [19:0] s;
    set_vec(pack10(vmx), pack10(vmx));
    start_op(1'b0, 2'b01);
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (s !== 20'd650250) begin miscompares++; $display("FAIL max_dot got %0d want 650250", s); end
    start_op(1'b0, 2'b11);
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (cyc !== 10) begin miscompares++; $display("FAIL reserved_latency got %0d want 10", cyc); end
    vectors++; if (s !== 20'd0) begin miscompares++; $display("FAIL reserved_sum got %0d want 0", s); end
  endtask

  task automatic test_lanes3();
    int cyc, bcyc;
    logic [19:0] s;
    set_vec(pack10(va1), pack10(vb1));
    start_op(1'b1, 2'b01);
    wait_done(1'b1, cyc, bcyc, s);
    vectors++; if (cyc !== 4) begin miscompares++; $display("FAIL lanes3_latency got %0d want 4", cyc); end
    vectors++; if (s !== 20'd1430) begin miscompares++; $display("FAIL lanes3_dot got %0d want 1430", s); end
    set_vec(pack10(vmx), pack10(vmx));
    start_op(1'b1, 2'b00);
    wait_done(1'b1, cyc, bcyc, s);
    vectors++; if (s !== 20'd5100) begin miscompares++; $display("FAIL lanes3_max_sum got %0d want 5100", s); end
  endtask

  task automatic test_reset_mid_run();
    int cyc, bcyc, n;
    logic [19:0] s;
    set_vec(pack10(va1), pack10(vb1));
    start_op(1'b0, 2'b01);
    repeat (4) @(posedge clk);
    #2 res = 1'b0;
    #1;
    vectors++; if (if1.busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy got %b want 0", if1.busy); end
    vectors++; if (if1.done !== 1'b0) begin miscompares++; $display("FAIL midrst_done got %b want 0", if1.done); end
    vectors++; if (if1.sum !== 20'd0) begin miscompares++; $display("FAIL midrst_sum got %0d want 0", if1.sum); end
    @(negedge clk);
    res = 1'b1;
    count_done(15, n);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL midrst_no_done got %0d want 0", n); end
    start_op(1'b0, 2'b00);
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (s !== 20'd210) begin miscompares++; $display("FAIL midrst_restart got %0d want 210", s); end
  endtask

  task automatic test_busy_start();
    int cyc, bcyc, n;
    logic [19:0] s;
    set_vec(pack10(va2), pack10(vb2));
    start_op(1'b0, 2'b10);
    repeat (2) @(posedge clk);
    #1;
    if1.start = 1'b1; if1.mode = 2'b00;
    @(posedge clk); #1;
    if1.start = 1'b0;
    wait_done(1'b0, cyc, bcyc, s);
    vectors++; if (cyc !== 7) begin miscompares++; $display("FAIL busy_start_latency got %0d want 7", cyc); end
    vectors++; if (s !== 20'd37) begin miscompares++; $display("FAIL busy_start_result got %0d want 37", s); end
    count_done(15, n);
    vectors++; if (n !== 0) begin miscompares++; $display("FAIL busy_start_second_done got %0d want 0", n); end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_mode_sum();
    test_back_to_back();
    test_mixed_vectors();
    test_max_and_reserved();
    test_lanes3();
    test_reset_mid_run();
    test_busy_start();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/array_mac_seq.md
Name: array_mac_seq

Overview:
- Parametrised sequential vector reduction engine; generalises the fixed 10×8-bit pairwise array sum.
- Latches two packed vectors of N elements, each W bits wide, on a start pulse.
- Reduces them over ceil(N/LANES) clock cycles in one of three modes: sum, dot product or sum of absolute differences (SAD).
- Returns the result with a one-cycle done pulse. Sits in the arithmetic datapath as a reusable reduction unit behind a simple start/busy/done handshake.

Parameters:
- N, 10: number of elements per vector (N ≥ 1).
- W, 8: element width in bits, unsigned.
- LANES, 1: elements processed per clock (1 ≤ LANES ≤ N; need not divide N).
- OUT_W, 2*W+$clog2(N): result width. Derived localparam; must not be overridden. Default evaluates to 20.

Ports:
- clk  input  1  system clock, rising edge.
- res  input  1  asynchronous active-low reset.
- start  input  1  request; sampled only in IDLE.
- mode  input  2  00 sum(a+b), 01 sum(a*b), 10 sum|a-b|, 11 reserved.
- num1  input  N*W  vector A; element k at bits [k*W +: W].
- num2  input  N*W  vector B; same packing.
- busy  output  1  high while the operation is in progress (state RUN).
- done  output  1  one-cycle pulse when sum is updated.
- sum  output  OUT_W  registered result.

Behaviour:
- Reset (res low, asynchronous): state IDLE; busy=0, done=0, sum=0; accumulator, index and latched operands cleared. Reset mid-RUN aborts silently with no done pulse.
- States: IDLE, RUN.
- IDLE, with start=1 at edge E0:
  - latch num1, num2 and mode;
  - acc=0, idx=0;
  - go to RUN, busy=1.
  - start=0: stay in IDLE.
- RUN, each edge:
  - acc += f(A[j],B[j]) for j = idx..idx+LANES-1; lanes with j ≥ N contribute 0;
  - idx += LANES.
- On the edge where idx+LANES ≥ N (edge E0+C, C=ceil(N/LANES)):
  - sum ← final acc in the same edge;
  - done=1 for exactly one cycle;
  - state returns to IDLE, busy=0.
- Latency: done and the new sum are visible C cycles after the start edge (N=10: LANES=1 → 10; LANES=3 → 4).
- f per mode:
  - 00: A+B, (W+1)-bit.
  - 01: A*B, 2W-bit.
  - 10: |A-B|, W-bit.
  - 11: 0. The operation still runs the full C cycles, pulses done and writes sum=0.
- Width: all arithmetic is unsigned, zero-extended to OUT_W. OUT_W guarantees no overflow in any mode. No wrap-around handling is required.
- Operand changes on num1, num2 or mode during RUN are ignored; only the latched copies are used.
- start while busy=1 is ignored, not queued.
- start in the cycle done=1 (state already IDLE) is accepted, giving back-to-back operation with no bubble beyond done.
- sum holds its value between completions and is not cleared on start.

Test Plan:
- Mode 00, LANES=1:
  - A = elements 9..0 = 2,4,…,20; B = 1,3,…,19; start one cycle.
  - Required: busy for 10 cycles, done pulse, sum=210.
- Same vectors, modes 01 and 10 back-to-back, start asserted in each done cycle:
  - mode 01 → sum=1430; mode 10 → sum=10.
  - Each done exactly 10 cycles after its start edge.
- A = elements 9..0 = 5,4,3,2,1,1,2,3,4,5; B = 1,2,…,10:
  - mode 00 → 85; mode 01 → 165; mode 10 → 37.
  - Change num1 to all-zero during RUN; result must be unchanged.
- Maximum values, all elements 255, mode 01 → sum=650250 (no overflow). Mode 11 → sum=0 with done pulse.
- LANES=3 build, mode 01 vector from test 2 → sum=1430 after exactly 4 cycles. The partial last lane must be ignored.
- Reset and handshake:
  - Pulse res low at cycle 5 of RUN: busy, done and sum go to 0 immediately, with no done pulse.
  - A following start completes normally.
  - A start asserted while busy produces no second done.
